uart_stimulus: RTL and testbench

- Bench-side UART transmitter that drives the SoC serial input `uart0_srx_pad_i`.
- Complements the existing UART decoder, which only observes `uart0_stx_pad_o`.
- Buffers host bytes in a small FIFO and serialises them as 8N1 frames at a parameterised bit period.
- Written as synthesizable RTL so the same block can drive a loopback on the DE10-Lite board.

---
 rtl/uart_stimulus_pkg.sv | 24 ++
 rtl/uart_stimulus_fifo.sv | 53 +++++
 rtl/uart_stimulus.sv | 175 +++++++++++++++++
 tb/tb_uart_stimulus.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stimulus_pkg.sv
// Shared types and helpers for the bench-side UART transmitter.
package uart_stimulus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int unsigned DATA_BITS = 8;

  // Ceiling log2; values of 0 or 1 give 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_stimulus_fifo.sv
// First-word-fall-through byte FIFO; level comes from pointers one bit wider than the address.
module uart_stimulus_fifo
  import uart_stimulus_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [7:0]              data_i,
  input  logic                    pop_i,
  output logic [7:0]              data_o,
  output logic [clog2(DEPTH):0]   level_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AddrW = clog2(DEPTH);

  logic [7:0]     r_mem [DEPTH];
  logic [AddrW:0] r_wr_ptr;
  logic [AddrW:0] r_rd_ptr;
  logic           w_push;
  logic           w_pop;

  assign level_o = r_wr_ptr - r_rd_ptr;
  assign full_o  = (level_o == (AddrW + 1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AddrW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_stimulus.sv
// Bench-side 8N1 UART transmitter fed from a byte FIFO.
// Define UART_STIMULUS_PARITY_EN to add a parity bit and the parity_odd_i input.
module uart_stimulus
  import uart_stimulus_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef UART_STIMULUS_PARITY_EN
  input  logic                         parity_odd_i,
`endif
  input  logic [7:0]                   data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic                         uart_rx_o,
  output logic                         busy_o,
  output logic [clog2(FIFO_DEPTH):0]   level_o,
  output logic                         tx_done_o
);

  localparam int unsigned       BaudW    = clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0]  BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0]        StopLast = 3'(STOP_BITS - 1);

  state_e           r_state, w_state_nxt;
  logic [BaudW-1:0] r_baud, w_baud_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_line, w_line_nxt;
  logic             r_done, w_done_nxt;
`ifdef UART_STIMULUS_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_baud_last;
  logic [7:0] w_head;

  assign ready_o     = ~w_full;
  assign w_push      = valid_i & ready_o;
  assign busy_o      = (r_state != IDLE) | ~w_empty;
  assign uart_rx_o   = r_line;
  assign tx_done_o   = r_done;
  assign w_baud_last = (r_baud == BaudLast);

  uart_stimulus_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .data_i  (data_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .level_o (level_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_line_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
`ifdef UART_STIMULUS_PARITY_EN
    w_par_nxt   = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_line_nxt = 1'b0;
        w_baud_nxt = r_baud + BaudW'(1);
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_line_nxt = r_shift[0];
        w_baud_nxt = r_baud + BaudW'(1);
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == DataLast) begin
            w_bit_nxt   = '0;
`ifdef UART_STIMULUS_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_STIMULUS_PARITY_EN
      PARITY: begin
        w_line_nxt = r_par;
        w_baud_nxt = r_baud + BaudW'(1);
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        w_baud_nxt = r_baud + BaudW'(1);
        if (w_baud_last) begin
          w_baud_nxt = '0;
          w_bit_nxt  = r_bit + 3'd1;
          if (r_bit == StopLast) begin
            w_done_nxt = 1'b1;
            // Chain straight into the next start bit when more data is queued.
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = START;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_pop) begin
      w_shift_nxt = w_head;
      w_baud_nxt  = '0;
`ifdef UART_STIMULUS_PARITY_EN
      w_par_nxt   = (^w_head) ^ parity_odd_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_line  <= 1'b1;
      r_done  <= 1'b0;
`ifdef UART_STIMULUS_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_line  <= w_line_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_STIMULUS_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_stimulus.sv
// Bench for uart_stimulus: directed frames plus random traffic decoded by a line monitor.
module tb_uart_stimulus;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_STIMULUS_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       uart_rx_o;
  logic       busy_o;
  logic [2:0] level_o;
  logic       tx_done_o;
`ifdef UART_STIMULUS_PARITY_EN
  logic       parity_odd;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  int         start_q[$];
  int         done_q[$];

  logic       mon_active = 1'b0;
  int         mon_i      = 0;
  int         mon_j      = 0;
  logic [7:0] mon_byte   = 8'h00;

  uart_stimulus #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .STOP_BITS    (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef UART_STIMULUS_PARITY_EN
    .parity_odd_i (parity_odd),
`endif
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .uart_rx_o    (uart_rx_o),
    .busy_o       (busy_o),
    .level_o      (level_o),
    .tx_done_o    (tx_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level of frame bit j for byte b: start, LSB-first data, optional parity, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_STIMULUS_PARITY_EN
    if (j == 9) return (^b) ^ parity_odd;
`endif
    return 1'b1;
  endfunction

  // Independent receiver: mid-bit sampling of the line on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx_done_o) done_q.push_back(cyc);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (!uart_rx_o) begin
          mon_active = 1'b1;
          mon_i      = 1;
          mon_byte   = 8'h00;
          start_q.push_back(cyc);
        end
      end else begin
        mon_i++;
        if ((mon_i - 1) % CPB == CPB / 2) begin
          mon_j = (mon_i - 1) / CPB;
          if (mon_j == 0) begin
            check("mon_start", 32'(uart_rx_o), 32'(0));
          end else if (mon_j <= 8) begin
            mon_byte[mon_j-1] = uart_rx_o;
`ifdef UART_STIMULUS_PARITY_EN
          end else if (mon_j == 9) begin
            check("mon_parity", 32'(uart_rx_o), 32'((^mon_byte) ^ parity_odd));
`endif
          end else begin
            check("mon_stop", 32'(uart_rx_o), 32'(1));
            dec_q.push_back(mon_byte);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    data_i  = b;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_o || mon_active) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n >= budget), 32'(0));
    repeat (3) tick();
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_count"}, 32'(dec_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++) begin
      check({tag, "_byte"}, 32'(dec_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    dec_q.delete();
    start_q.delete();
    done_q.delete();
  endtask

  // Push one byte into an idle block and check latency, every bit cell and the done pulse.
  task automatic frame_test(input logic [7:0] b, input string tag);
    logic       rec_line [FRAME_CYC + 5];
    logic       rec_done [FRAME_CYC + 5];
    logic [31:0] got;
    logic [31:0] exp;
    int          n_done;
    int          pos_done;
    check({tag, "_ready"}, 32'(ready_o), 32'(1));
    push_byte(b);
    exp_q.push_back(b);
    check({tag, "_lat_n"}, 32'(uart_rx_o), 32'(1));
    tick();
    check({tag, "_lat_n1"}, 32'(uart_rx_o), 32'(1));
    tick();
    check({tag, "_lat_n2"}, 32'(uart_rx_o), 32'(0));
    for (int i = 1; i <= FRAME_CYC + 4; i++) begin
      rec_line[i] = uart_rx_o;
      rec_done[i] = tx_done_o;
      tick();
    end
    for (int j = 0; j < FRAME_BITS; j++) begin
      got = '0;
      exp = '0;
      for (int k = 1; k <= CPB; k++) begin
        got = {got[30:0], rec_line[j*CPB + k]};
        exp = {exp[30:0], exp_bit(b, j)};
      end
      check($sformatf("%s_bit%0d", tag, j), got, exp);
    end
    n_done   = 0;
    pos_done = 0;
    for (int i = 1; i <= FRAME_CYC + 4; i++) begin
      if (rec_done[i]) begin
        n_done++;
        pos_done = i;
      end
    end
    check({tag, "_done_count"}, 32'(n_done), 32'(1));
    check({tag, "_done_pos"}, 32'(pos_done), 32'(FRAME_CYC));
  endtask

  initial begin
    int hi;
    int acc;
    int guard;
    int lvl_exp;
    logic rdy;
    logic [7:0] rb;

    rst_n   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
`ifdef UART_STIMULUS_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_line", 32'(uart_rx_o), 32'(1));
    check("rst_ready", 32'(ready_o), 32'(1));
    check("rst_level", 32'(level_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_done", 32'(tx_done_o), 32'(0));
    rst_n = 1'b1;

    hi = 0;
    repeat (20) begin
      tick();
      hi += int'(uart_rx_o);
    end
    check("idle_line_high", 32'(hi), 32'(20));
    check("idle_busy", 32'(busy_o), 32'(0));

    frame_test(8'hA5, "a5");
    wait_idle(100);
    check_queues("a5");

    // Back-to-back bytes: second start bit must follow the stop bit with no gap.
    data_i  = 8'h55;
    valid_i = 1'b1;
    tick();
    data_i  = 8'h0F;
    tick();
    valid_i = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    wait_idle(400);
    check("b2b_starts", 32'(start_q.size()), 32'(2));
    check("b2b_dones", 32'(done_q.size()), 32'(2));
    if (start_q.size() == 2 && done_q.size() == 2) begin
      check("b2b_start_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME_CYC));
      check("b2b_done_gap", 32'(done_q[1] - done_q[0]), 32'(FRAME_CYC));
      check("b2b_done_pos", 32'(done_q[0] - start_q[0]), 32'(FRAME_CYC - 1));
    end
    check_queues("b2b");

    // Hold valid high: one byte leaves for the line, then DEPTH more fill the FIFO.
    for (int k = 1; k <= 12; k++) begin
      data_i  = 8'(8'h10 + k);
      valid_i = 1'b1;
      rdy     = ready_o;
      check("full_ready", 32'(rdy), 32'(k <= DEPTH + 1));
      if (k <= DEPTH + 1) exp_q.push_back(data_i);
      tick();
      lvl_exp = (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
      check("full_level", 32'(level_o), 32'(lvl_exp));
    end
    valid_i = 1'b0;
    wait_idle(600);
    check_queues("full");

    // Random traffic with random valid gaps.
    acc   = 0;
    guard = 0;
    while (acc < 24 && guard < 4000) begin
      rb      = 8'($urandom);
      data_i  = rb;
      valid_i = 1'($urandom_range(0, 1));
      check("rand_ready", 32'(ready_o), 32'(level_o != 3'(DEPTH)));
      if (valid_i && ready_o) begin
        exp_q.push_back(rb);
        acc++;
      end
      tick();
      guard++;
    end
    valid_i = 1'b0;
    check("rand_accepted", 32'(acc), 32'(24));
    wait_idle(24 * FRAME_CYC + 400);
    check_queues("rand");

    // Reset during data bit 3 of a frame with another byte still queued.
    push_byte(8'h00);
    push_byte(8'h81);
    guard = 0;
    while (uart_rx_o && guard < 10) begin
      tick();
      guard++;
    end
    check("rst_mid_start", 32'(uart_rx_o), 32'(0));
    repeat (16) tick();
    check("rst_mid_pre", 32'(uart_rx_o), 32'(0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_line", 32'(uart_rx_o), 32'(1));
    check("rst_mid_level", 32'(level_o), 32'(0));
    check("rst_mid_busy", 32'(busy_o), 32'(0));
    check("rst_mid_ready", 32'(ready_o), 32'(1));
    exp_q.delete();
    dec_q.delete();
    start_q.delete();
    done_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_after_line", 32'(uart_rx_o), 32'(1));
    check("rst_after_busy", 32'(busy_o), 32'(0));
    push_byte(8'h3C);
    exp_q.push_back(8'h3C);
    wait_idle(200);
    check_queues("rst");

`ifdef UART_STIMULUS_PARITY_EN
    parity_odd = 1'b0;
    frame_test(8'h07, "par_even");
    wait_idle(100);
    check_queues("par_even");
    parity_odd = 1'b1;
    frame_test(8'h07, "par_odd");
    wait_idle(100);
    check_queues("par_odd");
    parity_odd = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
